// File: rtl/activation_stream_packer.sv
// Rounds/clamps 3-channel signed activations to 8-bit pixels and emits an AXI4-Stream video stream.
// Latency 1 cycle; registered ready drops only when the skid register is occupied, 2 pixels of storage.
module activation_stream_packer #(
  parameter int Height          = 600,
  parameter int Width           = 800,
  parameter int ActivationWidth = 10,
  parameter int FractionBits    = 2
) (
  input  logic                         clock_i,
  input  logic                         reset_ni,
  input  logic                         slave_valid_i,
  output logic                         slave_ready_o,
  input  logic [3*ActivationWidth-1:0] slave_data_i,
  output logic                         m_axis_tvalid_o,
  input  logic                         m_axis_tready_i,
  output logic [23:0]                  m_axis_tdata_o,
  output logic                         m_axis_tuser_o,
  output logic                         m_axis_tlast_o,
  output logic                         frame_done_o,
  output logic [15:0]                  clip_count_o
);

  localparam int AW = ActivationWidth;
  localparam int CW = (Width > 1) ? $clog2(Width) : 1;
  localparam int RW = (Height > 1) ? $clog2(Height) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(Width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(Height - 1);
  localparam int RND_I = (FractionBits > 0) ? 2 ** (FractionBits - 1) : 0;
  localparam logic signed [AW:0] RND = (AW + 1)'(RND_I);

  typedef struct packed {
    logic [23:0] dat;
    logic        sof;
    logic        eol;
    logic        eof;
    logic        clip;
  } pix_t;

  logic          r_rdy;
  logic          r_out_vld;
  pix_t          r_out;
  logic          r_skid_vld;
  pix_t          r_skid;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [15:0]   r_acc;
  logic [15:0]   r_clip_count;
  logic          r_done;

  logic signed [AW:0] w_x [3];
  int                 w_y [3];
  pix_t               w_in;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_out_free;
  logic               w_skid_vld_nxt;
  logic [15:0]        w_acc_inc;

  // Position and clip flags are resolved at acceptance so they travel with the pixel.
  always_comb begin
    w_in = '0;
    for (int c = 0; c < 3; c++) begin
      w_x[c] = {slave_data_i[c*AW+AW-1], slave_data_i[c*AW +: AW]};
      w_y[c] = int'(w_x[c] + RND) >>> FractionBits;
      if (w_y[c] > 255) begin
        w_in.dat[c*8 +: 8] = 8'hFF;
      end else if (w_y[c] >= 0) begin
        w_in.dat[c*8 +: 8] = 8'(w_y[c]);
      end
      if (w_y[c] < 0 || w_y[c] > 255) begin
        w_in.clip = 1'b1;
      end
    end
    w_in.sof = (r_col == '0) && (r_row == '0);
    w_in.eol = (r_col == COL_LAST);
    w_in.eof = (r_col == COL_LAST) && (r_row == ROW_LAST);
  end

  assign w_in_hs        = slave_valid_i & r_rdy;
  assign w_out_hs       = r_out_vld & m_axis_tready_i;
  assign w_out_free     = ~r_out_vld | w_out_hs;
  assign w_skid_vld_nxt = w_out_free ? (r_skid_vld & w_in_hs) : (r_skid_vld | w_in_hs);
  assign w_acc_inc      = (r_acc == 16'hFFFF) ? r_acc : r_acc + 16'd1;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_rdy        <= 1'b0;
      r_out_vld    <= 1'b0;
      r_out        <= '0;
      r_skid_vld   <= 1'b0;
      r_skid       <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_acc        <= '0;
      r_clip_count <= '0;
      r_done       <= 1'b0;
    end else begin
      r_rdy      <= ~w_skid_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      if (w_in_hs && (r_skid_vld || !w_out_free)) begin
        r_skid <= w_in;
      end
      // Skid content is older than the incoming pixel, so it always moves first.
      if (w_out_free) begin
        r_out_vld <= r_skid_vld | w_in_hs;
        if (r_skid_vld) begin
          r_out <= r_skid;
        end else if (w_in_hs) begin
          r_out <= w_in;
        end
      end
      if (w_in_hs) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      r_done <= w_out_hs & r_out.eof;
      if (w_out_hs) begin
        if (r_out.eof) begin
          r_clip_count <= r_out.clip ? w_acc_inc : r_acc;
          r_acc        <= '0;
        end else if (r_out.clip) begin
          r_acc <= w_acc_inc;
        end
      end
    end
  end

  assign slave_ready_o   = r_rdy;
  assign m_axis_tvalid_o = r_out_vld;
  assign m_axis_tdata_o  = r_out.dat;
  assign m_axis_tuser_o  = r_out.sof;
  assign m_axis_tlast_o  = r_out.eol;
  assign frame_done_o    = r_done;
  assign clip_count_o    = r_clip_count;

endmodule
